// File: rtl/sr_latch_bank_ctrl.sv
// Round-robin sequencer for a shared bank of gated SR latches: setup -> enable pulse -> hold.
// Optional readback check of lat_q during HOLD is enabled by defining SR_CTRL_VERIFY_EN.
module sr_latch_bank_ctrl #(
    parameter int N_REQ     = 4,
    parameter int W         = 8,
    parameter int PULSE_LEN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   op_set,
    input  logic [N_REQ*W-1:0] mask,
    output logic [N_REQ-1:0]   ack,
    output logic               busy,
    output logic               lat_en,
    output logic [W-1:0]       lat_s,
    output logic [W-1:0]       lat_r,
    input  logic [W-1:0]       lat_q,
    output logic               err
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0] gnt_reg, gnt_next;
    logic          op_reg, op_next;
    logic [W-1:0]  msk_reg, msk_next;
    logic [3:0]    cnt_reg, cnt_next;

    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [W-1:0]  sel_mask;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % N_REQ;
        return IW'(s);
    endfunction

    // First requester at or after rr_ptr, wrapping around the requester list.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr_reg;
        for (int k = 0; k < N_REQ; k++) begin
            if (!sel_found && req[wrap_add(rr_ptr_reg, k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(rr_ptr_reg, k);
            end
        end
    end

    assign sel_mask = mask[sel_idx*W +: W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            gnt_reg    <= '0;
            op_reg     <= 1'b0;
            msk_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            gnt_reg    <= gnt_next;
            op_reg     <= op_next;
            msk_reg    <= msk_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        gnt_next    = gnt_reg;
        op_next     = op_reg;
        msk_next    = msk_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    gnt_next    = sel_idx;
                    op_next     = op_set[sel_idx];
                    msk_next    = sel_mask;
                    rr_ptr_next = wrap_add(sel_idx, 1);
                    // An empty mask has nothing to drive, so skip straight to the ack.
                    state_next  = (sel_mask == '0) ? HOLD : SETUP;
                end
            end
            SETUP: begin
                cnt_next   = '0;
                state_next = PULSE;
            end
            PULSE: begin
                if (cnt_reg == 4'(PULSE_LEN - 1)) begin
                    cnt_next   = '0;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // s and r are derived from a single op bit, so they can never overlap.
    always_comb begin
        busy   = (state_reg != IDLE);
        lat_en = (state_reg == PULSE);
        lat_s  = (busy && op_reg)  ? msk_reg : '0;
        lat_r  = (busy && !op_reg) ? msk_reg : '0;
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
            assign ack[gi] = (state_reg == HOLD) && (gnt_reg == IW'(gi));
        end
    endgenerate

`ifdef SR_CTRL_VERIFY_EN
    logic err_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (state_reg == HOLD &&
                     ((lat_q & msk_reg) != (op_reg ? msk_reg : '0))) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    logic unused_lat_q;
    assign unused_lat_q = ^lat_q;
    assign err          = 1'b0;
`endif

endmodule
